// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the 8N1 UART receive path.
// The transmitter uses the same baud/width defaults and state encodings.
package uart_rx_pkg;

  localparam int UART_CLKS_PER_BIT = 868;
  localparam int UART_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rxd line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* dont_touch = "true" *) logic meta_q;
  (* dont_touch = "true" *) logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop FSM with 2-of-3 majority per bit,
// a valid/ready holding register and sticky framing/overrun flags.
//
// Handshake: rx_data is stable while rx_valid=1; a byte is consumed on any cycle
// with rx_valid & rx_ready, and rx_valid only drops on the edge after that cycle.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  input  logic                 clear_err,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);
  localparam int HALF = CLKS_PER_BIT / 2;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] SMP0    = CW'(CLKS_PER_BIT - 3);
  localparam logic [CW-1:0] SMP1    = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] LAST    = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rxd_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (reset),
    .d   (rxd),
    .q   (rxd_s)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           smp_q, smp_d;
  logic                 rxd_prev_q, rxd_prev_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;

  logic bit_v;
  logic frame_done;
  logic frame_good;
  logic accept;

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    smp_d       = smp_q;
    rxd_prev_d  = rxd_s;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    frame_done  = 1'b0;
    frame_good  = 1'b0;
    bit_v       = maj3(smp_q[0], smp_q[1], rxd_s);
    accept      = rx_valid_q & rx_ready;

    case (state_q)
      ST_IDLE: begin
        // Only a real 1->0 transition arms the receiver, never a held-low line.
        if (rxd_prev_q && !rxd_s) begin
          state_d = ST_START;
          baud_d  = '0;
        end
      end
      ST_START: begin
        if (baud_q == HALF_M1) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      ST_DATA, ST_STOP: begin
        if (baud_q == SMP0) smp_d[0] = rxd_s;
        if (baud_q == SMP1) smp_d[1] = rxd_s;
        if (baud_q == LAST) begin
          baud_d = '0;
          if (state_q == ST_DATA) begin
            shift_d   = {bit_v, shift_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + BW'(1);
            if (bit_idx_q == LAST_BIT) state_d = ST_STOP;
          end else begin
            state_d    = ST_IDLE;
            frame_done = 1'b1;
            frame_good = bit_v;
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Clear first so an error arriving with clear_err still leaves its flag set.
    if (clear_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (frame_done && !frame_good) begin
      frame_err_d = 1'b1;
      if (accept) rx_valid_d = 1'b0;
    end else if (frame_done) begin
      if (!rx_valid_q || accept) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      smp_q       <= '0;
      rxd_prev_q  <= 1'b1;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      smp_q       <= smp_d;
      rxd_prev_q  <= rxd_prev_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: frame-level model plus per-cycle compare.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam int DW  = 8;
  // Stop-bit midpoint measured from the first clock edge that sees the start bit.
  localparam int MID_OFS = (DW + 1) * CPB + CPB / 2;

  logic          clk;
  logic          reset;
  logic          rxd;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          frame_err;
  logic          overrun;
  logic          clear_err;
  logic          busy;
  logic [1:0]    state_dbg;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .clear_err (clear_err),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [DW-1:0] exp_q[$];   // bytes of frames in flight
  int            mid_q[$];   // stop-bit midpoint cycle of each frame
  logic          ok_q[$];    // stop bit value of each frame

  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0;
  logic          m_ferr  = 1'b0;
  logic          m_ovr   = 1'b0;
  logic          seen    = 1'b0;
  logic [DW-1:0] seen_d  = '0;

  logic rdy_e, clr_e, rst_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: outputs are meaningful on every cycle except the few around
  // a stop-bit midpoint, where the byte lands within a bounded latency.
  always @(posedge clk) begin
    logic [DW-1:0] b;
    logic          ok;
    int            m;
    cyc++;
    rdy_e = rx_ready;
    clr_e = clear_err;
    rst_e = reset;
    #1;
    if (rst_e) begin
      m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0; seen = 1'b0;
      exp_q.delete(); mid_q.delete(); ok_q.delete();
      check("rst_data", rx_data, 0);
      check("rst_valid", rx_valid, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovr", overrun, 0);
      check("rst_busy", busy, 0);
    end else if (mid_q.size() > 0 && cyc >= mid_q[0] && cyc < mid_q[0] + 3) begin
      if (rx_valid === 1'b1 && !seen) begin
        seen   = 1'b1;
        seen_d = rx_data;
      end
    end else begin
      if (clr_e) begin
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
      end
      if (mid_q.size() > 0 && cyc == mid_q[0] + 3) begin
        b  = exp_q.pop_front();
        ok = ok_q.pop_front();
        m  = mid_q.pop_front();
        if (!ok) begin
          m_ferr = 1'b1;
          if (m_valid && rdy_e) m_valid = 1'b0;
        end else if (!m_valid || rdy_e) begin
          check("deliver_seen", seen, 1);
          check("deliver_data", seen_d, b);
          m_data  = b;
          m_valid = !rdy_e;
        end else begin
          m_ovr = 1'b1;
        end
        seen = 1'b0;
      end else if (m_valid && rdy_e) begin
        m_valid = 1'b0;
      end
      check("cyc_valid", rx_valid, m_valid);
      if (m_valid) check("cyc_data", rx_data, m_data);
      check("cyc_ferr", frame_err, m_ferr);
      check("cyc_ovr", overrun, m_ovr);
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] b, input logic stop, input int spike_slot);
    logic [DW+1:0] fr;
    int s;
    fr = {stop, b, 1'b0};
    s  = cyc + 1;
    exp_q.push_back(b);
    ok_q.push_back(stop);
    mid_q.push_back(s + MID_OFS);
    for (int j = 0; j < DW + 2; j++) begin
      for (int k = 0; k < CPB; k++) begin
        rxd = (j == spike_slot && k == CPB / 2) ? ~fr[j] : fr[j];
        @(negedge clk);
      end
    end
    rxd = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [DW-1:0] part;
    reset = 1'b1; rxd = 1'b1; rx_ready = 1'b0; clear_err = 1'b0;
    idle(3);
    check("reset_state", state_dbg, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    idle(5);

    // Clean frame, consumer always ready: one-cycle valid pulse carrying 0xA5.
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1, -1);
    idle(20);
    check("a5_data", rx_data, 8'hA5);
    check("a5_valid", rx_valid, 0);
    check("a5_ferr", frame_err, 0);

    // Six-cycle low glitch: START is entered then abandoned with no flag.
    rxd = 1'b0;
    idle(6);
    rxd = 1'b1;
    check("glitch_busy_hi", busy, 1);
    check("glitch_state_start", state_dbg, 1);
    idle(10);
    check("glitch_busy_lo", busy, 0);
    check("glitch_state_idle", state_dbg, 0);
    check("glitch_ferr", frame_err, 0);
    idle(10);

    // Stop bit forced low: framing error, byte discarded.
    rx_ready = 1'b0;
    send_frame(8'h3C, 1'b0, -1);
    idle(20);
    check("ferr_set", frame_err, 1);
    check("ferr_valid", rx_valid, 0);
    pulse_clear();
    check("ferr_clear", frame_err, 0);
    idle(5);

    // Two frames with no consumer: first byte held, second dropped, overrun.
    send_frame(8'h11, 1'b1, -1);
    idle(20);
    check("busy_mid_check", busy, 0);
    send_frame(8'h22, 1'b1, -1);
    idle(20);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_valid", rx_valid, 1);
    check("ovr_flag", overrun, 1);
    pulse_ready();
    check("ovr_accepted", rx_valid, 0);
    pulse_clear();
    check("ovr_clear", overrun, 0);
    idle(5);

    // Inverted spike at the middle of data bit 3: majority vote keeps 0x55.
    send_frame(8'h55, 1'b1, 4);
    idle(20);
    check("spike_data", rx_data, 8'h55);
    check("spike_valid", rx_valid, 1);
    pulse_ready();
    idle(5);

    // Reset halfway through the data bits of a frame; partial byte is lost.
    part = 8'h99;
    rxd = 1'b0;
    idle(CPB);
    for (int j = 0; j < DW / 2; j++) begin
      rxd = part[j];
      idle(CPB);
    end
    check("partial_busy", busy, 1);
    reset = 1'b1;
    rxd   = 1'b1;
    idle(3);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", rx_valid, 0);
    check("mid_rst_data", rx_data, 0);
    reset = 1'b0;
    idle(1);
    check("post_rst_idle", state_dbg, 0);
    idle(10);
    rx_ready = 1'b1;
    send_frame(8'hF0, 1'b1, -1);
    idle(20);
    check("f0_data", rx_data, 8'hF0);
    check("f0_ferr", frame_err, 0);
    check("f0_ovr", overrun, 0);
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
